// File: rtl/impact_sram_sequencer.sv
// Host-side initiator that steps the IMPACT SRAM macro through its control phases.
// Define IMPACT_SEQ_VERIFY_EN to add a read-back verify after every write.
module impact_sram_sequencer #(
   parameter int PRE_CYC = 2,
   parameter int DIN_CYC = 1,
   parameter int ACC_CYC = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [1:0] cmd_byte_sel,
   input  logic [1:0] cmd_proj_sel,
   input  logic       cmd_byte_mode,
   input  logic       cmd_trunc,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_err,
   output logic       busy,
   output logic       sram_precharge,
   output logic       sram_data_in_en,
   output logic       sram_wl_en,
   output logic       sram_write_en,
   output logic       sram_read_en,
   output logic       sram_byte_mode,
   output logic       sram_trunc,
   output logic [1:0] sram_byte_sel,
   output logic [1:0] sram_proj_sel,
   output logic [7:0] sram_data_in,
   input  logic [7:0] sram_data_out
);

   // Both handshakes transfer on a rising clk edge where valid and ready are high;
   // the offering side holds its payload stable until that edge.
   localparam int MAX_CYC = (PRE_CYC > DIN_CYC) ?
                            ((PRE_CYC > ACC_CYC) ? PRE_CYC : ACC_CYC) :
                            ((DIN_CYC > ACC_CYC) ? DIN_CYC : ACC_CYC);
   localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CW-1:0] PRE_LD = CW'(PRE_CYC - 1);
   localparam logic [CW-1:0] DIN_LD = CW'(DIN_CYC - 1);
   localparam logic [CW-1:0] ACC_LD = CW'(ACC_CYC - 1);

`ifdef IMPACT_SEQ_VERIFY_EN
   typedef enum logic [2:0] {IDLE, PRE, LOAD, ACCESS, DONE, VPRE, VACC} state_t;
`else
   typedef enum logic [2:0] {IDLE, PRE, LOAD, ACCESS, DONE} state_t;
`endif

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          wr_q;
   logic [7:0]    wdata_q;
   logic          sample;
   logic          accept;
   logic          pc_nxt, die_nxt, wl_nxt, we_nxt, re_nxt;
   logic [7:0]    din_nxt;

   assign cmd_ready = (state == IDLE) && !rst;
   assign accept    = cmd_ready && cmd_valid;
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sample    = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               state_nxt = PRE;
               cnt_nxt   = PRE_LD;
            end
         end
         PRE: begin
            if (cnt == '0) begin
               if (wr_q) begin
                  state_nxt = LOAD;
                  cnt_nxt   = DIN_LD;
               end else begin
                  state_nxt = ACCESS;
                  cnt_nxt   = ACC_LD;
               end
            end else cnt_nxt = cnt - CW'(1);
         end
         LOAD: begin
            if (cnt == '0) begin
               state_nxt = ACCESS;
               cnt_nxt   = ACC_LD;
            end else cnt_nxt = cnt - CW'(1);
         end
         ACCESS: begin
            if (cnt == '0) begin
`ifdef IMPACT_SEQ_VERIFY_EN
               if (wr_q) begin
                  state_nxt = VPRE;
                  cnt_nxt   = PRE_LD;
               end else begin
                  state_nxt = DONE;
                  sample    = 1'b1;
               end
`else
               state_nxt = DONE;
               sample    = !wr_q;
`endif
            end else cnt_nxt = cnt - CW'(1);
         end
`ifdef IMPACT_SEQ_VERIFY_EN
         VPRE: begin
            if (cnt == '0) begin
               state_nxt = VACC;
               cnt_nxt   = ACC_LD;
            end else cnt_nxt = cnt - CW'(1);
         end
         VACC: begin
            if (cnt == '0) begin
               state_nxt = DONE;
               sample    = 1'b1;
            end else cnt_nxt = cnt - CW'(1);
         end
`endif
         DONE: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Pin enables are decoded from the next state so they flip on the same
      // edge as the state register, leaving no gap between phases.
      pc_nxt  = 1'b0;
      die_nxt = 1'b0;
      wl_nxt  = 1'b0;
      we_nxt  = 1'b0;
      re_nxt  = 1'b0;
      din_nxt = 8'h00;
      case (state_nxt)
         PRE:  pc_nxt = 1'b1;
         LOAD: begin
            die_nxt = 1'b1;
            din_nxt = wdata_q;
         end
         ACCESS: begin
            wl_nxt  = 1'b1;
            we_nxt  = wr_q;
            re_nxt  = !wr_q;
            din_nxt = wr_q ? wdata_q : 8'h00;
         end
`ifdef IMPACT_SEQ_VERIFY_EN
         VPRE: pc_nxt = 1'b1;
         VACC: begin
            wl_nxt = 1'b1;
            re_nxt = 1'b1;
         end
`endif
         default: ;
      endcase
   end

`ifdef IMPACT_SEQ_VERIFY_EN
   logic rsp_err_q;
   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= '0;
         wr_q            <= 1'b0;
         wdata_q         <= 8'h00;
         rsp_valid       <= 1'b0;
         rsp_data        <= 8'h00;
         sram_precharge  <= 1'b0;
         sram_data_in_en <= 1'b0;
         sram_wl_en      <= 1'b0;
         sram_write_en   <= 1'b0;
         sram_read_en    <= 1'b0;
         sram_byte_mode  <= 1'b0;
         sram_trunc      <= 1'b0;
         sram_byte_sel   <= 2'b00;
         sram_proj_sel   <= 2'b00;
         sram_data_in    <= 8'h00;
`ifdef IMPACT_SEQ_VERIFY_EN
         rsp_err_q       <= 1'b0;
`endif
      end else begin
         state           <= state_nxt;
         cnt             <= cnt_nxt;
         rsp_valid       <= (state_nxt == DONE);
         sram_precharge  <= pc_nxt;
         sram_data_in_en <= die_nxt;
         sram_wl_en      <= wl_nxt;
         sram_write_en   <= we_nxt;
         sram_read_en    <= re_nxt;
         sram_data_in    <= din_nxt;
         if (accept) begin
            wr_q           <= cmd_write;
            wdata_q        <= cmd_wdata;
            sram_byte_sel  <= cmd_byte_sel;
            sram_proj_sel  <= cmd_proj_sel;
            sram_byte_mode <= cmd_byte_mode;
            sram_trunc     <= cmd_trunc;
            rsp_data       <= 8'h00;
`ifdef IMPACT_SEQ_VERIFY_EN
            rsp_err_q      <= 1'b0;
`endif
         end else if (state == DONE && rsp_ready) begin
            sram_byte_sel  <= 2'b00;
            sram_proj_sel  <= 2'b00;
            sram_byte_mode <= 1'b0;
            sram_trunc     <= 1'b0;
         end
         if (sample) begin
            rsp_data  <= sram_data_out;
`ifdef IMPACT_SEQ_VERIFY_EN
            rsp_err_q <= wr_q && (sram_data_out != wdata_q);
`endif
         end
      end
   end

endmodule

// File: tb/tb_impact_sram_sequencer.sv
// Self-checking bench for impact_sram_sequencer: table vectors, a mid-write reset
// sequence and randomized commands checked against a per-cycle phase model.
module tb_impact_sram_sequencer;

   localparam int PRE_CYC = 2;
   localparam int DIN_CYC = 1;
   localparam int ACC_CYC = 3;
`ifdef IMPACT_SEQ_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_write = 1'b0;
   logic [1:0] cmd_byte_sel = 2'b00;
   logic [1:0] cmd_proj_sel = 2'b00;
   logic       cmd_byte_mode = 1'b0;
   logic       cmd_trunc = 1'b0;
   logic [7:0] cmd_wdata = 8'h00;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic       busy;
   logic       sram_precharge, sram_data_in_en, sram_wl_en, sram_write_en, sram_read_en;
   logic       sram_byte_mode, sram_trunc;
   logic [1:0] sram_byte_sel, sram_proj_sel;
   logic [7:0] sram_data_in;
   logic [7:0] sram_data_out = 8'h00;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      bit         wr;
      logic [1:0] bsel;
      logic [1:0] psel;
      bit         bmode;
      bit         trunc;
      logic [7:0] wdata;
      logic [7:0] dout;
      int         hold;
      logic [7:0] exp_data;
      bit         exp_err;
   } vec_t;

   vec_t vecs[6];

   impact_sram_sequencer #(.PRE_CYC(PRE_CYC), .DIN_CYC(DIN_CYC), .ACC_CYC(ACC_CYC)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_byte_sel(cmd_byte_sel), .cmd_proj_sel(cmd_proj_sel),
      .cmd_byte_mode(cmd_byte_mode), .cmd_trunc(cmd_trunc), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .busy(busy),
      .sram_precharge(sram_precharge), .sram_data_in_en(sram_data_in_en),
      .sram_wl_en(sram_wl_en), .sram_write_en(sram_write_en), .sram_read_en(sram_read_en),
      .sram_byte_mode(sram_byte_mode), .sram_trunc(sram_trunc),
      .sram_byte_sel(sram_byte_sel), .sram_proj_sel(sram_proj_sel),
      .sram_data_in(sram_data_in), .sram_data_out(sram_data_out)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
   endtask

   function automatic logic [18:0] sram_all();
      return {sram_precharge, sram_data_in_en, sram_wl_en, sram_write_en, sram_read_en,
              sram_byte_mode, sram_trunc, sram_byte_sel, sram_proj_sel, sram_data_in};
   endfunction

   function automatic logic [7:0] status_vec();
      return {sram_precharge, sram_data_in_en, sram_wl_en, sram_write_en, sram_read_en,
              rsp_valid, busy, cmd_ready};
   endfunction

   // driver: offer one command, walk every cycle of the transaction against the
   // phase schedule, then hold the response for v.hold cycles before consuming it
   task automatic run_cmd(input vec_t v, input bit rnd);
      int p, d, a, vp, va, total, waitc;
      logic [7:0] cap, exp_data, exp_vec;
      bit exp_err, in_pre, in_load, in_acc, in_vpre, in_vacc;
      p     = PRE_CYC;
      d     = v.wr ? DIN_CYC : 0;
      a     = ACC_CYC;
      vp    = (VERIFY && v.wr) ? PRE_CYC : 0;
      va    = (VERIFY && v.wr) ? ACC_CYC : 0;
      total = p + d + a + vp + va;
      cmd_write     = v.wr;
      cmd_byte_sel  = v.bsel;
      cmd_proj_sel  = v.psel;
      cmd_byte_mode = v.bmode;
      cmd_trunc     = v.trunc;
      cmd_wdata     = v.wdata;
      cmd_valid     = 1'b1;
      sram_data_out = v.dout;
      rsp_ready     = (v.hold == 0);
      waitc = 0;
      while (cmd_ready !== 1'b1 && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (cmd_ready !== 1'b1) begin
         check("accept_timeout", {31'd0, cmd_ready}, 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      cmd_valid     = 1'b0;
      cmd_write     = 1'($urandom);
      cmd_byte_sel  = 2'($urandom);
      cmd_proj_sel  = 2'($urandom);
      cmd_byte_mode = 1'($urandom);
      cmd_trunc     = 1'($urandom);
      cmd_wdata     = 8'($urandom);
      cap = v.dout;
      for (int k = 1; k <= total; k++) begin
         @(negedge clk);
         in_pre  = (k <= p);
         in_load = (k > p) && (k <= p + d);
         in_acc  = (k > p + d) && (k <= p + d + a);
         in_vpre = (k > p + d + a) && (k <= p + d + a + vp);
         in_vacc = (k > p + d + a + vp);
         exp_vec = {in_pre || in_vpre, in_load, in_acc || in_vacc, in_acc && v.wr,
                    (in_acc && !v.wr) || in_vacc, 1'b0, 1'b1, 1'b0};
         check($sformatf("phase[%0d]", k), {24'd0, status_vec()}, {24'd0, exp_vec});
         check("overlap", {31'd0, (32'(sram_precharge) + 32'(sram_data_in_en) + 32'(sram_wl_en)) <= 1}, 32'd1);
         check("sel", {26'd0, sram_byte_sel, sram_proj_sel, sram_byte_mode, sram_trunc},
               {26'd0, v.bsel, v.psel, v.bmode, v.trunc});
         if (in_load || (in_acc && v.wr)) check("data_in", {24'd0, sram_data_in}, {24'd0, v.wdata});
         if (rnd) begin
            sram_data_out = 8'($urandom);
            if (k == total) cap = sram_data_out;
         end
      end
      if (rnd) begin
         exp_data = (v.wr && !VERIFY) ? 8'h00 : cap;
         exp_err  = VERIFY && v.wr && (cap != v.wdata);
      end else begin
         exp_data = v.exp_data;
         exp_err  = v.exp_err;
      end
      exp_q.push_back(exp_data);
      for (int h = 0; h <= v.hold; h++) begin
         @(negedge clk);
         check("done_status", {24'd0, status_vec()}, 32'h06);
         check("rsp_data", {24'd0, rsp_data}, {24'd0, exp_q[0]});
         check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
         check("done_sel", {26'd0, sram_byte_sel, sram_proj_sel, sram_byte_mode, sram_trunc},
               {26'd0, v.bsel, v.psel, v.bmode, v.trunc});
         sram_data_out = 8'($urandom);
         rsp_ready = (h == v.hold);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
      check("after_handshake", {29'd0, rsp_valid, busy, cmd_ready}, 32'd1);
      rsp_ready = 1'b0;
   endtask

   task automatic reset_mid_write();
      int waitc;
      cmd_write = 1'b1; cmd_byte_sel = 2'd1; cmd_proj_sel = 2'd3;
      cmd_byte_mode = 1'b1; cmd_trunc = 1'b0; cmd_wdata = 8'h99;
      cmd_valid = 1'b1;
      rsp_ready = 1'b1;
      waitc = 0;
      while (cmd_ready !== 1'b1 && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      check("rst_accept", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      check("rst_cmd_ready_0", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      check("rst_sram_1", {13'd0, sram_all()}, 32'd0);
      check("rst_rsp_1", {31'd0, rsp_valid}, 32'd0);
      check("rst_cmd_ready_1", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      check("rst_sram_2", {13'd0, sram_all()}, 32'd0);
      check("rst_cmd_ready_2", {31'd0, cmd_ready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {30'd0, cmd_ready, busy}, 32'd2);
      check("post_rst_sram", {13'd0, sram_all()}, 32'd0);
      waitc = 0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || busy !== 1'b0) waitc++;
      end
      check("dropped_no_rsp", waitc, 32'd0);
      rsp_ready = 1'b0;
   endtask

   initial begin
      vec_t r;
      vecs[0] = '{wr: 1, bsel: 2, psel: 1, bmode: 0, trunc: 0, wdata: 8'hA5, dout: 8'hA5,
                  hold: 0, exp_data: VERIFY ? 8'hA5 : 8'h00, exp_err: 0};
      vecs[1] = '{wr: 0, bsel: 0, psel: 0, bmode: 0, trunc: 0, wdata: 8'h00, dout: 8'h3C,
                  hold: 0, exp_data: 8'h3C, exp_err: 0};
      vecs[2] = '{wr: 0, bsel: 3, psel: 2, bmode: 1, trunc: 1, wdata: 8'h11, dout: 8'hC3,
                  hold: 5, exp_data: 8'hC3, exp_err: 0};
      vecs[3] = '{wr: 1, bsel: 1, psel: 3, bmode: 1, trunc: 0, wdata: 8'h5A, dout: 8'h58,
                  hold: 2, exp_data: VERIFY ? 8'h58 : 8'h00, exp_err: VERIFY};
      vecs[4] = '{wr: 1, bsel: 0, psel: 2, bmode: 0, trunc: 1, wdata: 8'h5A, dout: 8'h5A,
                  hold: 0, exp_data: VERIFY ? 8'h5A : 8'h00, exp_err: 0};
      vecs[5] = '{wr: 1, bsel: 3, psel: 0, bmode: 1, trunc: 1, wdata: 8'hFF, dout: 8'h00,
                  hold: 1, exp_data: 8'h00, exp_err: VERIFY};

      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_sram", {13'd0, sram_all()}, 32'd0);
      check("reset_rsp", {22'd0, rsp_valid, rsp_err, rsp_data}, 32'd0);
      check("reset_ready", {30'd0, cmd_ready, busy}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("reset_release_ready", {31'd0, cmd_ready}, 32'd1);

      for (int i = 0; i < 6; i++) run_cmd(vecs[i], 1'b0);

      reset_mid_write();

      for (int i = 0; i < 100; i++) begin
         r.wr       = 1'($urandom_range(0, 1));
         r.bsel     = 2'($urandom_range(0, 3));
         r.psel     = 2'($urandom_range(0, 3));
         r.bmode    = 1'($urandom_range(0, 1));
         r.trunc    = 1'($urandom_range(0, 1));
         r.wdata    = 8'($urandom_range(0, 255));
         r.dout     = 8'($urandom_range(0, 255));
         r.hold     = $urandom_range(0, 2);
         r.exp_data = 8'h00;
         r.exp_err  = 1'b0;
         run_cmd(r, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
